// File: rtl/fruit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fruit_ctrl_pkg
//  Description : Shared state encoding and helpers for the N-fruit game
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fruit_ctrl_pkg;

    // Widest fruit vector the popcount helper has to handle
    localparam int c_max_fruits = 8;

    // Game FSM encoding; the raw value is exported on the state port
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_PAUSED = 3'd2,
        ST_OVER   = 3'd3,
        ST_WIN    = 3'd4
    } state_e;

    // Number of set bits in a (zero-padded) fruit vector
    function automatic logic [3:0] popcount(input logic [c_max_fruits-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < c_max_fruits; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fruit_chan.sv
`default_nettype none
// ============================================================================
//  Module      : fruit_chan
//  Description : One fruit channel: active-edge history, cut flag and
//                cut / miss / respawn generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fruit_chan
    import fruit_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_play,
    input  logic i_start,
    input  logic i_frame_tick,
    input  logic i_active,
    input  logic i_hit,
    output logic o_cut,
    output logic o_miss,
    output logic o_respawn
);

    logic active_q, active_d;
    logic cut_q, cut_d;
    logic respawn_q, respawn_d;
    logic w_rise;
    logic w_fall;

    // Edge detection, event classification and next-state of the channel flags
    always_comb begin
        w_rise = i_active & ~active_q;
        w_fall = ~i_active & active_q;

        // A cut is only possible while the fruit is in flight, so it can
        // never coincide with a falling edge; the guard on o_miss keeps the
        // cut dominant regardless.
        o_cut  = i_play & i_frame_tick & i_active & i_hit & ~cut_q;
        o_miss = i_play & w_fall & ~cut_q & ~o_cut;

        // History tracks every cycle so that leaving pause sees no false edge
        active_d = i_active;

        cut_d = cut_q;
        if (i_play && w_rise) begin
            cut_d = 1'b0;
        end
        if (o_cut) begin
            cut_d = 1'b1;
        end

        respawn_d = i_start | o_cut | o_miss;
    end

    // Channel registers; reset also drops any pending respawn pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            cut_q     <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            cut_q     <= cut_d;
            respawn_q <= respawn_d;
        end
    end

    assign o_respawn = respawn_q;

endmodule
`default_nettype wire

// File: rtl/fruit_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : fruit_ctrl_n
//  Description : Game controller for NUM_FRUITS fruits: FSM, saturating
//                score / miss counters and sub-counter based level logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module fruit_ctrl_n
    import fruit_ctrl_pkg::*;
#(
    parameter int NUM_FRUITS = 3,
    parameter int SCORE_W    = 10,
    parameter int MISS_W     = 8,
    parameter int MAX_MISS   = 10,
    parameter int MAX_SCORE  = 999,
    parameter int LEVEL_STEP = 25,
    parameter int NUM_LEVELS = 4,
    parameter int LVL_W      = 2
) (
    input  logic                  ck,
    input  logic                  on,
    input  logic                  frame_tick,
    input  logic                  pause,
    input  logic [NUM_FRUITS-1:0] active,
    input  logic [NUM_FRUITS-1:0] hit,
    output logic [NUM_FRUITS-1:0] respawn,
    output logic [SCORE_W-1:0]    score,
    output logic [MISS_W-1:0]     missed,
    output logic [LVL_W-1:0]      level,
    output logic [2:0]            state,
    output logic                  go,
    output logic                  max
);

    // Sub-counter only ever holds < LEVEL_STEP + NUM_FRUITS < 2*LEVEL_STEP
    localparam int                 c_sub_w       = $clog2(2 * LEVEL_STEP);
    localparam logic [SCORE_W-1:0] c_max_score   = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W+3:0] c_max_score_x = (SCORE_W + 4)'(MAX_SCORE);
    localparam logic [MISS_W-1:0]  c_max_miss    = MISS_W'(MAX_MISS);
    localparam logic [MISS_W+3:0]  c_max_miss_x  = (MISS_W + 4)'(MAX_MISS);
    localparam logic [c_sub_w+3:0] c_step_x      = (c_sub_w + 4)'(LEVEL_STEP);
    localparam logic [LVL_W-1:0]   c_top_level   = LVL_W'(NUM_LEVELS - 1);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [MISS_W-1:0]    missed_q, missed_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [c_sub_w-1:0]   sub_q, sub_d;

    logic                 w_start;
    logic                 w_play;
    logic [NUM_FRUITS-1:0] w_cut;
    logic [NUM_FRUITS-1:0] w_miss;
    logic [c_max_fruits-1:0] w_cut_pad;
    logic [c_max_fruits-1:0] w_miss_pad;
    logic [3:0]           w_n_cut;
    logic [3:0]           w_n_miss;
    logic [SCORE_W+3:0]   w_score_sum;
    logic [MISS_W+3:0]    w_miss_sum;
    logic [c_sub_w+3:0]   w_sub_sum;

    assign w_play = (state_q == ST_PLAY);

    // Per-fruit channels
    for (genvar gi = 0; gi < NUM_FRUITS; gi++) begin : g_chan
        fruit_chan u_chan (
            .clk          (ck),
            .rst_n        (on),
            .i_play       (w_play),
            .i_start      (w_start),
            .i_frame_tick (frame_tick),
            .i_active     (active[gi]),
            .i_hit        (hit[gi]),
            .o_cut        (w_cut[gi]),
            .o_miss       (w_miss[gi]),
            .o_respawn    (respawn[gi])
        );
    end

    // Game FSM next state; win is checked before loss so it takes priority
    always_comb begin
        state_d = state_q;
        w_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_PLAY;
                    w_start = 1'b1;
                end
            end
            ST_PLAY: begin
                if (score_q == c_max_score) begin
                    state_d = ST_WIN;
                end else if (missed_q == c_max_miss) begin
                    state_d = ST_OVER;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!pause) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER, ST_WIN: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating score / miss counters and level sub-counter
    always_comb begin
        w_cut_pad                   = '0;
        w_cut_pad[NUM_FRUITS-1:0]   = w_cut;
        w_miss_pad                  = '0;
        w_miss_pad[NUM_FRUITS-1:0]  = w_miss;
        w_n_cut                     = popcount(w_cut_pad);
        w_n_miss                    = popcount(w_miss_pad);

        w_score_sum = {4'b0000, score_q} + {{SCORE_W{1'b0}}, w_n_cut};
        w_miss_sum  = {4'b0000, missed_q} + {{MISS_W{1'b0}}, w_n_miss};
        w_sub_sum   = {4'b0000, sub_q} + {{c_sub_w{1'b0}}, w_n_cut};

        score_d  = (w_score_sum >= c_max_score_x) ? c_max_score : SCORE_W'(w_score_sum);
        missed_d = (w_miss_sum >= c_max_miss_x) ? c_max_miss : MISS_W'(w_miss_sum);

        // Subtract instead of dividing; at most one level step per cycle
        level_d = level_q;
        if (w_sub_sum >= c_step_x) begin
            sub_d = c_sub_w'(w_sub_sum - c_step_x);
            if (level_q != c_top_level) begin
                level_d = level_q + LVL_W'(1);
            end
        end else begin
            sub_d = c_sub_w'(w_sub_sum);
        end
    end

    // FSM and counter registers
    always_ff @(posedge ck) begin
        if (!on) begin
            state_q  <= ST_IDLE;
            score_q  <= '0;
            missed_q <= '0;
            level_q  <= '0;
            sub_q    <= '0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            missed_q <= missed_d;
            level_q  <= level_d;
            sub_q    <= sub_d;
        end
    end

    assign score  = score_q;
    assign missed = missed_q;
    assign level  = level_q;
    assign state  = state_q;
    assign go     = (state_q == ST_OVER) || (state_q == ST_WIN);
    assign max    = (state_q == ST_WIN);

endmodule
`default_nettype wire

// File: tb/tb_fruit_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fruit_ctrl_n
//  Description : Self-checking bench for fruit_ctrl_n (3 fruits, default
//                thresholds): vector table, directed game sequences and a
//                randomized run against a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fruit_ctrl_n;

    localparam int NF    = 3;
    localparam int MAXS  = 999;
    localparam int MAXM  = 10;
    localparam int STEP  = 25;
    localparam int NLV   = 4;

    localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSED = 2, S_OVER = 3, S_WIN = 4;

    logic          ck  = 1'b0;
    logic          on  = 1'b0;
    logic          ft  = 1'b0;
    logic          pz  = 1'b0;
    logic [NF-1:0] act = '0;
    logic [NF-1:0] hit = '0;

    logic [NF-1:0] respawn;
    logic [9:0]    score;
    logic [7:0]    missed;
    logic [1:0]    level;
    logic [2:0]    state;
    logic          go;
    logic          max_o;

    fruit_ctrl_n dut (
        .ck         (ck),
        .on         (on),
        .frame_tick (ft),
        .pause      (pz),
        .active     (act),
        .hit        (hit),
        .respawn    (respawn),
        .score      (score),
        .missed     (missed),
        .level      (level),
        .state      (state),
        .go         (go),
        .max        (max_o)
    );

    always #5 ck = ~ck;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural game model
    int            m_state, m_score, m_missed, m_level, m_sub;
    bit            m_cut  [NF];
    bit            m_prev [NF];
    logic [NF-1:0] m_resp;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, a, e, $time);
        end
    endtask

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        int            cuts;
        int            misses;
        int            nxt;
        logic [NF-1:0] resp;
        bit            play;
        bit            start;
        if (!on) begin
            m_state = S_IDLE; m_score = 0; m_missed = 0; m_level = 0; m_sub = 0;
            m_resp  = '0;
            for (int i = 0; i < NF; i++) begin
                m_cut[i]  = 1'b0;
                m_prev[i] = 1'b0;
            end
            return;
        end
        play   = (m_state == S_PLAY);
        start  = (m_state == S_IDLE) && ft;
        cuts   = 0;
        misses = 0;
        resp   = '0;
        for (int i = 0; i < NF; i++) begin
            bit a    = act[i];
            bit rise = a && !m_prev[i];
            bit fall = !a && m_prev[i];
            if (play && ft && a && hit[i] && !m_cut[i]) begin
                cuts++;
                resp[i]  = 1'b1;
                m_cut[i] = 1'b1;
            end else begin
                if (play && fall && !m_cut[i]) begin
                    misses++;
                    resp[i] = 1'b1;
                end
                if (play && rise) m_cut[i] = 1'b0;
            end
            m_prev[i] = a;
        end
        nxt = m_state;
        case (m_state)
            S_IDLE:   if (ft) nxt = S_PLAY;
            S_PLAY:   if (m_score == MAXS) nxt = S_WIN;
                      else if (m_missed == MAXM) nxt = S_OVER;
                      else if (pz) nxt = S_PAUSED;
            S_PAUSED: if (!pz) nxt = S_PLAY;
            default:  nxt = m_state;
        endcase
        m_score  = (m_score + cuts > MAXS) ? MAXS : m_score + cuts;
        m_missed = (m_missed + misses > MAXM) ? MAXM : m_missed + misses;
        m_sub    = m_sub + cuts;
        if (m_sub >= STEP) begin
            m_sub = m_sub - STEP;
            if (m_level < NLV - 1) m_level++;
        end
        m_resp  = start ? '1 : resp;
        m_state = nxt;
    endtask

    task automatic check_model();
        chk("model_state",   32'(state),   32'(m_state));
        chk("model_score",   32'(score),   32'(m_score));
        chk("model_missed",  32'(missed),  32'(m_missed));
        chk("model_level",   32'(level),   32'(m_level));
        chk("model_respawn", 32'(respawn), 32'(m_resp));
        chk("model_go",      32'(go),      32'(m_state == S_OVER || m_state == S_WIN));
        chk("model_max",     32'(max_o),   32'(m_state == S_WIN));
    endtask

    // Apply one cycle of inputs, clock, then compare against the model
    task automatic step(input logic o, input logic f, input logic p,
                        input logic [NF-1:0] a, input logic [NF-1:0] h);
        on = o; ft = f; pz = p; act = a; hit = h;
        model_step();
        @(posedge ck);
        #1;
        check_model();
    endtask

    typedef struct {
        logic          on_v;
        logic          ft_v;
        logic          pz_v;
        logic [NF-1:0] act_v;
        logic [NF-1:0] hit_v;
        int            e_state;
        int            e_score;
        int            e_missed;
        int            e_level;
        logic [NF-1:0] e_resp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [NF-1:0] ra;

        // on ft pz act hit | state score missed level respawn
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, S_IDLE, 0, 0, 0, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, S_IDLE, 0, 0, 0, 3'b000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, S_PLAY, 0, 0, 0, 3'b111};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b001, 3'b000, S_PLAY, 0, 0, 0, 3'b000};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b001, 3'b001, S_PLAY, 1, 0, 0, 3'b001};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b001, 3'b000, S_PLAY, 1, 0, 0, 3'b000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, S_PLAY, 1, 0, 0, 3'b000};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b100, 3'b000, S_PLAY, 1, 0, 0, 3'b000};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, S_PLAY, 1, 1, 0, 3'b100};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b011, 3'b000, S_PLAY, 1, 1, 0, 3'b000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b011, 3'b011, S_PLAY, 3, 1, 0, 3'b011};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b011, 3'b011, S_PLAY, 3, 1, 0, 3'b000};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, S_PLAY, 3, 1, 0, 3'b000};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].on_v, vecs[i].ft_v, vecs[i].pz_v, vecs[i].act_v, vecs[i].hit_v);
            chk($sformatf("v%0d_state", i),   32'(state),   32'(vecs[i].e_state));
            chk($sformatf("v%0d_score", i),   32'(score),   32'(vecs[i].e_score));
            chk($sformatf("v%0d_missed", i),  32'(missed),  32'(vecs[i].e_missed));
            chk($sformatf("v%0d_level", i),   32'(level),   32'(vecs[i].e_level));
            chk($sformatf("v%0d_respawn", i), 32'(respawn), 32'(vecs[i].e_resp));
        end

        // Single cuts up to 24 points, then a double cut crosses the level step
        for (int r = 0; r < 21; r++) begin
            step(1, 0, 0, 3'b001, 3'b000);
            step(1, 1, 0, 3'b001, 3'b001);
            step(1, 0, 0, 3'b000, 3'b000);
        end
        chk("pre_double_score", 32'(score), 32'd24);
        chk("pre_double_level", 32'(level), 32'd0);
        step(1, 0, 0, 3'b011, 3'b000);
        step(1, 1, 0, 3'b011, 3'b011);
        chk("double_score", 32'(score), 32'd26);
        chk("double_level", 32'(level), 32'd1);
        chk("double_resp",  32'(respawn), 32'b011);
        step(1, 0, 0, 3'b000, 3'b000);

        // Pause: nothing counts, and leaving pause with steady active is quiet
        step(1, 0, 1, 3'b000, 3'b000);
        chk("pause_state", 32'(state), 32'(S_PAUSED));
        step(1, 1, 1, 3'b001, 3'b001);
        step(1, 1, 1, 3'b001, 3'b001);
        chk("pause_hit_score", 32'(score), 32'd26);
        chk("pause_hit_resp",  32'(respawn), 32'b000);
        step(1, 0, 1, 3'b000, 3'b000);
        chk("pause_fall_missed", 32'(missed), 32'd1);
        step(1, 0, 1, 3'b100, 3'b000);
        step(1, 0, 0, 3'b100, 3'b000);
        chk("resume_state",  32'(state),  32'(S_PLAY));
        chk("resume_missed", 32'(missed), 32'd1);
        chk("resume_resp",   32'(respawn), 32'b000);
        step(1, 0, 0, 3'b100, 3'b000);
        step(1, 0, 0, 3'b000, 3'b000);
        chk("resumed_miss", 32'(missed), 32'd2);

        // Miss limit: ten unhit falls end the game
        step(0, 0, 0, 3'b000, 3'b000);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_score", 32'(score), 32'd0);
        step(1, 1, 0, 3'b000, 3'b000);
        for (int r = 0; r < 10; r++) begin
            step(1, 0, 0, 3'b100, 3'b000);
            step(1, 0, 0, 3'b000, 3'b000);
        end
        chk("miss10_missed", 32'(missed), 32'd10);
        chk("miss10_state",  32'(state),  32'(S_PLAY));
        step(1, 0, 0, 3'b000, 3'b000);
        chk("over_state", 32'(state), 32'(S_OVER));
        chk("over_go",    32'(go), 32'd1);
        chk("over_max",   32'(max_o), 32'd0);
        step(1, 0, 0, 3'b100, 3'b000);
        step(1, 0, 1, 3'b000, 3'b000);
        chk("over_missed_sticky", 32'(missed), 32'd10);
        chk("over_pause_ignored", 32'(state), 32'(S_OVER));

        // Win: climb to 998 with triple/double cuts, then saturate at 999
        step(0, 0, 0, 3'b000, 3'b000);
        step(1, 1, 0, 3'b000, 3'b000);
        for (int r = 0; r < 332; r++) begin
            step(1, 0, 0, 3'b111, 3'b000);
            step(1, 1, 0, 3'b111, 3'b111);
            step(1, 0, 0, 3'b000, 3'b000);
        end
        step(1, 0, 0, 3'b011, 3'b000);
        step(1, 1, 0, 3'b011, 3'b011);
        step(1, 0, 0, 3'b000, 3'b000);
        chk("score_998", 32'(score), 32'd998);
        step(1, 0, 0, 3'b011, 3'b000);
        step(1, 1, 0, 3'b011, 3'b011);
        chk("score_sat",   32'(score), 32'd999);
        chk("level_sat",   32'(level), 32'd3);
        chk("win_pending", 32'(state), 32'(S_PLAY));
        step(1, 0, 0, 3'b000, 3'b000);
        chk("win_state", 32'(state), 32'(S_WIN));
        chk("win_max",   32'(max_o), 32'd1);
        chk("win_go",    32'(go), 32'd1);
        step(0, 1, 0, 3'b111, 3'b111);
        chk("rst2_state",   32'(state),   32'(S_IDLE));
        chk("rst2_score",   32'(score),   32'd0);
        chk("rst2_missed",  32'(missed),  32'd0);
        chk("rst2_level",   32'(level),   32'd0);
        chk("rst2_respawn", 32'(respawn), 32'd0);
        chk("rst2_go",      32'(go),      32'd0);
        chk("rst2_max",     32'(max_o),   32'd0);

        // Randomized play against the model, with occasional mid-game resets
        ra = '0;
        for (int c = 0; c < 600; c++) begin
            logic ro;
            ro = ($urandom_range(0, 79) != 0);
            ra = ra ^ NF'($urandom_range(0, 7) & $urandom_range(0, 7));
            step(ro, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                 ra, NF'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
